// File: rtl/efpga_periph_responder.sv
// rtl/efpga_periph_responder.sv - eFPGA bus responder backed by a small register file
//
// Peripheral-side end of the eFPGA address/valid/ready bus. Accepts one request
// at a time, acknowledges the address phase, collects write data, optionally
// inserts WAIT_CYCLES wait states, then holds the response until accepted.
//
// Optional feature macro: PERIPH_RESP_ERR_EN (adds resp_err_o, flags out-of-window access).
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req_addr_valid_i    request valid; addr_i and rd_wr sampled with it (1 = write)
//   wdata_i/_valid_i    write data and its qualifier, used only while resp_w_ready_o=1
//   resp_r_b_ready_i    initiator accepts the response
//   resp_addr_ready_o   one-cycle address-phase acknowledge
//   resp_w_ready_o      responder waiting for write data
//   resp_r_b_valid_o    read data / write ack valid
//   resp_rdata_o        read data, 0 unless a read response is being presented
//   resp_err_o          (PERIPH_RESP_ERR_EN only) out-of-window flag with the response
module efpga_periph_responder #(
  parameter int                ADDR_W      = 23,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 23'h200000,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_addr_valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rd_wr,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wdata_valid_i,
  input  logic              resp_r_b_ready_i,
  output logic              resp_addr_ready_o,
  output logic              resp_w_ready_o,
  output logic              resp_r_b_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o
`ifdef PERIPH_RESP_ERR_EN
  ,
  output logic              resp_err_o
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WAIT, S_RESP} state_t;

  // Command phases complete straight into RESP when no wait states are configured.
  localparam state_t     AFTER_CMD = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];

  // Window decode on the latched address. The full-width subtraction wraps for
  // addresses below BASE_ADDR, so the explicit lower-bound test is required.
  logic [ADDR_W-1:0]   idx;
  logic [IDX_W-1:0]    reg_idx;
  logic                in_win;

  assign idx     = addr_q - BASE_ADDR;
  assign reg_idx = idx[IDX_W-1:0];
  assign in_win  = (addr_q >= BASE_ADDR) && (idx < ADDR_W'(DEPTH));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_addr_valid_i) state_d = S_ADDR;
      S_ADDR:  state_d = wr_q ? S_WDATA : AFTER_CMD;
      S_WDATA: if (wdata_valid_i) state_d = AFTER_CMD;
      S_WAIT:  if (wait_cnt_q == 8'd0) state_d = S_RESP;
      S_RESP:  if (resp_r_b_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, write commit, wait counter, response data capture
  always_comb begin
    addr_d     = addr_q;
    wr_d       = wr_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    regs_d     = regs_q;

    if (state_q == S_IDLE && req_addr_valid_i) begin
      addr_d = addr_i;
      wr_d   = rd_wr;
    end

    // Out-of-window writes complete normally but never touch the file.
    if (state_q == S_WDATA && wdata_valid_i && in_win) begin
      regs_d[reg_idx] = wdata_i;
    end

    if (state_q != S_WAIT && state_d == S_WAIT) begin
      wait_cnt_d = WAIT_LOAD;
    end else if (state_q == S_WAIT && wait_cnt_q != 8'd0) begin
      wait_cnt_d = wait_cnt_q - 8'd1;
    end

    // Read data is frozen on RESP entry so it stays stable under backpressure.
    if (state_q != S_RESP && state_d == S_RESP) begin
      rdata_d = (in_win && !wr_q) ? regs_q[reg_idx] : '0;
    end
  end

  // Moore outputs
  always_comb begin
    resp_addr_ready_o = (state_q == S_ADDR);
    resp_w_ready_o    = (state_q == S_WDATA);
    resp_r_b_valid_o  = (state_q == S_RESP);
    resp_rdata_o      = (state_q == S_RESP) ? rdata_q : '0;
`ifdef PERIPH_RESP_ERR_EN
    resp_err_o        = (state_q == S_RESP) && !in_win;
`else
    // Out-of-window accesses complete silently: reads return 0, writes are dropped.
`endif
  end

endmodule

// File: tb/tb_efpga_periph_responder.sv
// tb/tb_efpga_periph_responder.sv - directed self-checking bench for efpga_periph_responder
//
// dut0 runs with WAIT_CYCLES=0, dut1 with WAIT_CYCLES=3. Inputs are driven 1 time
// unit after each rising edge and outputs are observed at the same point.
module tb_efpga_periph_responder;

  localparam int AW = 23;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, req_v, rd_wr, wdata_v, resp_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  wire  [1:0]    a_rdy, w_rdy, rb_v;
  wire  [DW-1:0] rdata0, rdata1;
`ifdef PERIPH_RESP_ERR_EN
  wire  [1:0]    err_o;
`endif

  int checks = 0;
  int errors = 0;

  efpga_periph_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk               (clk),
    .reset             (rst[0]),
    .req_addr_valid_i  (req_v[0]),
    .addr_i            (addr),
    .rd_wr             (rd_wr[0]),
    .wdata_i           (wdata),
    .wdata_valid_i     (wdata_v[0]),
    .resp_r_b_ready_i  (resp_ready[0]),
    .resp_addr_ready_o (a_rdy[0]),
    .resp_w_ready_o    (w_rdy[0]),
    .resp_r_b_valid_o  (rb_v[0]),
    .resp_rdata_o      (rdata0)
`ifdef PERIPH_RESP_ERR_EN
    ,
    .resp_err_o        (err_o[0])
`endif
  );

  efpga_periph_responder #(.WAIT_CYCLES(3)) dut1 (
    .clk               (clk),
    .reset             (rst[1]),
    .req_addr_valid_i  (req_v[1]),
    .addr_i            (addr),
    .rd_wr             (rd_wr[1]),
    .wdata_i           (wdata),
    .wdata_valid_i     (wdata_v[1]),
    .resp_r_b_ready_i  (resp_ready[1]),
    .resp_addr_ready_o (a_rdy[1]),
    .resp_w_ready_o    (w_rdy[1]),
    .resp_r_b_valid_o  (rb_v[1]),
    .resp_rdata_o      (rdata1)
`ifdef PERIPH_RESP_ERR_EN
    ,
    .resp_err_o        (err_o[1])
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on dut s; lat counts cycles from request to r_b_valid (-1 on timeout).
  task automatic do_xfer(input bit s, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd,
                         output int lat, output logic er);
    addr = a; wdata = d; rd_wr[s] = w; wdata_v[s] = w; req_v[s] = 1'b1; resp_ready[s] = 1'b0;
    lat = 0; er = 1'b0;
    while (!rb_v[s] && lat < 40) begin
      tick();
      lat++;
      if (a_rdy[s]) req_v[s] = 1'b0;
    end
    rd = s ? rdata1 : rdata0;
`ifdef PERIPH_RESP_ERR_EN
    er = err_o[s];
`endif
    if (!rb_v[s]) begin
      req_v[s] = 1'b0;
      lat = -1;
    end
    resp_ready[s] = 1'b1;
    tick();
    resp_ready[s] = 1'b0; wdata_v[s] = 1'b0; rd_wr[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 2'b11; req_v = '0; rd_wr = '0; wdata_v = '0; resp_ready = '0; addr = '0; wdata = '0;
    tick(); tick();
    checks++;
    if ({a_rdy, w_rdy, rb_v} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b want 000000", {a_rdy, w_rdy, rb_v}); end
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0)
      begin errors++; $display("FAIL reset_rdata got %h/%h want 0", rdata0, rdata1); end
`ifdef PERIPH_RESP_ERR_EN
    checks++;
    if (err_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", err_o); end
`endif
    rst = 2'b00;
  endtask

  task automatic test_basic_read();
    addr = 23'h200003; rd_wr[0] = 1'b0; req_v[0] = 1'b1;
    tick();
    checks++;
    if (a_rdy[0] !== 1'b1 || rb_v[0] !== 1'b0)
      begin errors++; $display("FAIL rd_addr_phase got a=%b v=%b want a=1 v=0", a_rdy[0], rb_v[0]); end
    req_v[0] = 1'b0;
    tick();
    checks++;
    if (a_rdy[0] !== 1'b0 || rb_v[0] !== 1'b1 || rdata0 !== 32'h0)
      begin errors++; $display("FAIL rd_resp got a=%b v=%b d=%h want a=0 v=1 d=0", a_rdy[0], rb_v[0], rdata0); end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    checks++;
    if (rb_v[0] !== 1'b0) begin errors++; $display("FAIL rd_done got v=%b want 0", rb_v[0]); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; int lat; logic er;
    do_xfer(1'b0, 23'h200005, 1'b1, 32'hDEADBEEF, rd, lat, er);
    checks++;
    if (lat !== 3 || rd !== 32'h0)
      begin errors++; $display("FAIL wr_lat got lat=%0d d=%h want lat=3 d=0", lat, rd); end
    do_xfer(1'b0, 23'h200005, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rd_back got lat=%0d d=%h want lat=2 d=deadbeef", lat, rd); end
    do_xfer(1'b0, 23'h200004, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rd_neighbor got %h want 0", rd); end
  endtask

  task automatic test_delayed_wdata();
    logic [DW-1:0] rd; int lat; logic er; int n;
    addr = 23'h200007; wdata = 32'h12345678; rd_wr[0] = 1'b1; wdata_v[0] = 1'b0; req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w_rdy[0]) n++;
      if (i == 3) wdata_v[0] = 1'b1;
    end
    tick();
    checks++;
    if (n !== 4) begin errors++; $display("FAIL w_ready_len got %0d want 4", n); end
    checks++;
    if (w_rdy[0] !== 1'b0 || rb_v[0] !== 1'b1 || rdata0 !== 32'h0)
      begin errors++; $display("FAIL w_ack got w=%b v=%b d=%h want w=0 v=1 d=0", w_rdy[0], rb_v[0], rdata0); end
    wdata = 32'hFFFFFFFF;
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0; wdata_v[0] = 1'b0; rd_wr[0] = 1'b0;
    checks++;
    if (rb_v[0] !== 1'b0) begin errors++; $display("FAIL w_done got v=%b want 0", rb_v[0]); end
    do_xfer(1'b0, 23'h200007, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL w_commit got %h want 12345678", rd); end
  endtask

  task automatic test_backpressure();
    addr = 23'h200005; rd_wr[0] = 1'b0; req_v[0] = 1'b1; resp_ready[0] = 1'b0;
    tick();
    req_v[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rb_v[0] !== 1'b1 || rdata0 !== 32'hDEADBEEF)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=deadbeef", i, rb_v[0], rdata0); end
      if (i < 4) tick();
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    checks++;
    if (rb_v[0] !== 1'b0 || rdata0 !== 32'h0)
      begin errors++; $display("FAIL bp_release got v=%b d=%h want v=0 d=0", rb_v[0], rdata0); end
  endtask

  task automatic test_window();
    logic [DW-1:0] rd; int lat; logic er;
    do_xfer(1'b0, 23'h20000F, 1'b1, 32'hA5A5A5A5, rd, lat, er);
    do_xfer(1'b0, 23'h20000F, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL win_last got %h want a5a5a5a5", rd); end
`ifdef PERIPH_RESP_ERR_EN
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL win_last_err got %b want 0", er); end
`endif
    do_xfer(1'b0, 23'h200010, 1'b1, 32'h11111111, rd, lat, er);
`ifdef PERIPH_RESP_ERR_EN
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL win_hi_wr_err got %b want 1", er); end
`endif
    do_xfer(1'b0, 23'h200010, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL win_hi_rd got d=%h lat=%0d want d=0 lat=2", rd, lat); end
    do_xfer(1'b0, 23'h200000, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL win_hi_alias got %h want 0", rd); end
    do_xfer(1'b0, 23'h1FFFFF, 1'b1, 32'h22222222, rd, lat, er);
    do_xfer(1'b0, 23'h1FFFFF, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL win_lo_rd got %h want 0", rd); end
`ifdef PERIPH_RESP_ERR_EN
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL win_lo_err got %b want 1", er); end
`endif
    do_xfer(1'b0, 23'h20000F, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL win_lo_alias got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_back_to_back();
    addr = 23'h200005; rd_wr[0] = 1'b0; req_v[0] = 1'b1; resp_ready[0] = 1'b1;
    tick();
    checks++;
    if (a_rdy[0] !== 1'b1 || rb_v[0] !== 1'b0)
      begin errors++; $display("FAIL b2b_a1 got a=%b v=%b want a=1 v=0", a_rdy[0], rb_v[0]); end
    tick();
    checks++;
    if (rb_v[0] !== 1'b1 || rdata0 !== 32'hDEADBEEF || a_rdy[0] !== 1'b0)
      begin errors++; $display("FAIL b2b_r1 got v=%b d=%h a=%b want v=1 d=deadbeef a=0", rb_v[0], rdata0, a_rdy[0]); end
    tick();
    checks++;
    if (a_rdy[0] !== 1'b0 || rb_v[0] !== 1'b0)
      begin errors++; $display("FAIL b2b_idle got a=%b v=%b want a=0 v=0", a_rdy[0], rb_v[0]); end
    tick();
    checks++;
    if (a_rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_a2 got a=%b want 1", a_rdy[0]); end
    req_v[0] = 1'b0;
    tick();
    checks++;
    if (rb_v[0] !== 1'b1 || rdata0 !== 32'hDEADBEEF)
      begin errors++; $display("FAIL b2b_r2 got v=%b d=%h want v=1 d=deadbeef", rb_v[0], rdata0); end
    tick();
    resp_ready[0] = 1'b0;
    checks++;
    if (rb_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_done got v=%b want 0", rb_v[0]); end
  endtask

  task automatic test_reset_mid_write();
    logic [DW-1:0] rd; int lat; logic er;
    addr = 23'h200006; wdata = 32'h55555555; rd_wr[0] = 1'b1; wdata_v[0] = 1'b0; req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    checks++;
    if ({a_rdy[0], w_rdy[0], rb_v[0]} !== 3'b000)
      begin errors++; $display("FAIL rst_wdata got %b want 000", {a_rdy[0], w_rdy[0], rb_v[0]}); end
    wdata_v[0] = 1'b1;
    tick();
    wdata_v[0] = 1'b0; rd_wr[0] = 1'b0;
    do_xfer(1'b0, 23'h200006, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_lost got %h want 0", rd); end
    do_xfer(1'b0, 23'h200005, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_clear got %h want 0", rd); end
  endtask

  task automatic test_wait();
    logic [DW-1:0] rd; int lat; logic er; int gap; bit seen;
    do_xfer(1'b1, 23'h200001, 1'b1, 32'hCAFEF00D, rd, lat, er);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL wait_wr_lat got %0d want 6", lat); end
    addr = 23'h200001; rd_wr[1] = 1'b0; req_v[1] = 1'b1;
    tick();
    checks++;
    if (a_rdy[1] !== 1'b1) begin errors++; $display("FAIL wait_addr got %b want 1", a_rdy[1]); end
    req_v[1] = 1'b0;
    gap = 0;
    tick();
    while (!rb_v[1] && gap < 20) begin
      gap++;
      tick();
    end
    checks++;
    if (gap !== 3) begin errors++; $display("FAIL wait_gap got %0d want 3", gap); end
    checks++;
    if (rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_rdata got %h want cafef00d", rdata1); end
    resp_ready[1] = 1'b1;
    tick();
    resp_ready[1] = 1'b0;
    req_v[1] = 1'b1;
    tick();
    req_v[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    checks++;
    if ({a_rdy[1], w_rdy[1], rb_v[1]} !== 3'b000)
      begin errors++; $display("FAIL wait_rst got %b want 000", {a_rdy[1], w_rdy[1], rb_v[1]}); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rb_v[1] || a_rdy[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL wait_rst_quiet got %b want 0", seen); end
    do_xfer(1'b1, 23'h200001, 1'b0, 32'h0, rd, lat, er);
    checks++;
    if (rd !== 32'h0 || lat !== 5)
      begin errors++; $display("FAIL wait_rst_clear got d=%h lat=%0d want d=0 lat=5", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_delayed_wdata();
    test_backpressure();
    test_window();
    test_back_to_back();
    test_reset_mid_write();
    test_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
